// File: rtl/acl_pkg.sv
// Shared types and constants for the accelerometer sample scheduler.
package acl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_EVAL      = 2'd3
  } acl_state_t;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  localparam int unsigned ACL_PEND_BIT = 0;
  localparam int unsigned ACL_MASK_LSB = 1;
  localparam int unsigned ACL_MASK_W   = 3;
  localparam int unsigned ACL_AXIS_LSB = 4;
  localparam int unsigned ACL_AXIS_W   = 2;
  localparam int unsigned ACL_DATA_LSB = 6;
  localparam int unsigned ACL_DATA_W   = 10;

  // Widened to 11 bits so that -512 maps to +512 without overflow.
  function automatic logic [10:0] acl_mag(input logic [9:0] d);
    logic [10:0] s;
    s = {d[9], d};
    return s[10] ? (~s + 11'd1) : s;
  endfunction

endpackage

// File: rtl/acl_tick_gen.sv
// Free-running prescaler; tick is high for the one cycle the counter wraps.
module acl_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned    CW   = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0]  LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/acl_sample_scheduler.sv
// Periodic X/Y/Z SPI read sequencer with thresholding and a sticky event word.
module acl_sample_scheduler
  import acl_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter logic [10:0] THRESH     = 11'd384,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        spi_start,
  output logic [1:0]  spi_axis,
  input  logic        spi_done,
  input  logic [9:0]  spi_data,
  input  logic        has_been_read,
  output logic [15:0] acl_out,
  output logic        busy,
  output logic        err_timeout
);
  localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  acl_state_t    r_state, w_state_nxt;
  logic [1:0]    r_axis, w_axis_nxt;
  logic [TW-1:0] r_to_cnt;
  logic [9:0]    r_data;
  logic [15:0]   r_acl;
  logic          r_err;
  logic          w_tick, w_timeout, w_hit;
  logic [2:0]    w_axis_bit;
  logic [15:0]   w_fresh;

  acl_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_axis  <= AX_X;
    end else begin
      r_state <= w_state_nxt;
      r_axis  <= w_axis_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_axis_nxt  = r_axis;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && enable) begin
          w_state_nxt = ST_REQ;
          w_axis_nxt  = AX_X;
        end
      end
      ST_REQ: w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (spi_done) begin
          w_state_nxt = ST_EVAL;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = (r_axis == AX_Z) ? ST_IDLE : ST_REQ;
          w_axis_nxt  = (r_axis == AX_X) ? AX_Y : AX_Z;
        end
      end
      ST_EVAL: begin
        w_state_nxt = (r_axis == AX_Z) ? ST_IDLE : ST_REQ;
        w_axis_nxt  = (r_axis == AX_X) ? AX_Y : AX_Z;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_to_cnt <= '0;
    else if (r_state != ST_WAIT_DONE) r_to_cnt <= '0;
    else                              r_to_cnt <= r_to_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_data <= '0;
    else if (r_state == ST_WAIT_DONE && spi_done) r_data <= spi_data;
  end

  assign w_hit      = (r_state == ST_EVAL) && (acl_mag(r_data) >= THRESH);
  assign w_axis_bit = 3'b001 << r_axis;

  always_comb begin
    w_fresh = '0;
    w_fresh[ACL_PEND_BIT]                = 1'b1;
    w_fresh[ACL_MASK_LSB +: ACL_MASK_W]  = w_axis_bit;
    w_fresh[ACL_AXIS_LSB +: ACL_AXIS_W]  = r_axis;
    w_fresh[ACL_DATA_LSB +: ACL_DATA_W]  = r_data;
  end

  // A hit coinciding with a clear reloads the word so the new event survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acl <= '0;
    end else if (w_hit) begin
      if (has_been_read || !r_acl[ACL_PEND_BIT])
        r_acl <= w_fresh;
      else
        r_acl[ACL_MASK_LSB +: ACL_MASK_W] <= r_acl[ACL_MASK_LSB +: ACL_MASK_W] | w_axis_bit;
    end else if (has_been_read) begin
      r_acl <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_err <= 1'b0;
    else if (w_timeout)     r_err <= 1'b1;
    else if (has_been_read) r_err <= 1'b0;
  end

  assign spi_start   = (r_state == ST_REQ);
  assign spi_axis    = r_axis;
  assign busy        = (r_state != ST_IDLE);
  assign acl_out     = r_acl;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_acl_sample_scheduler.sv
// Directed bench for acl_sample_scheduler with an SPI responder and event-word scoreboard.
module tb_acl_sample_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        spi_start;
  logic [1:0]  spi_axis;
  logic        spi_done;
  logic [9:0]  spi_data;
  logic        has_been_read;
  logic [15:0] acl_out;
  logic        busy;
  logic        err_timeout;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] sb_q[$];
  logic [1:0]  start_log[$];
  logic [9:0]  samp[3];
  logic        withhold[3];
  logic        clr_on_z;
  logic        sb_mark;
  logic [15:0] m_acl;

  acl_sample_scheduler #(
    .SAMPLE_DIV (32),
    .THRESH     (11'd384),
    .TIMEOUT    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .spi_start     (spi_start),
    .spi_axis      (spi_axis),
    .spi_done      (spi_done),
    .spi_data      (spi_data),
    .has_been_read (has_been_read),
    .acl_out       (acl_out),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference event-word update for one evaluated sample.
  function automatic logic [15:0] next_word(input logic [15:0] w, input logic [1:0] a,
                                            input logic [9:0] d, input logic clr);
    int mag;
    logic [15:0] r;
    mag = d[9] ? (1024 - int'(d)) : int'(d);
    r = clr ? 16'h0000 : w;
    if (mag >= 384) begin
      if (r[0] == 1'b0) r = {d, a, 3'b000, 1'b1};
      r[1 + a] = 1'b1;
    end
    return r;
  endfunction

  task automatic wait_busy(input logic lvl, input string tag);
    int unsigned k = 0;
    while (busy !== lvl && k < 80) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic wait_start_axis(input logic [1:0] ax, input string tag);
    int unsigned k = 0;
    while (!(spi_start === 1'b1 && spi_axis === ax) && k < 80) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, {31'd0, spi_start}, 32'd1);
  endtask

  task automatic pulse_hbr();
    has_been_read = 1'b1;
    @(posedge clk); #1;
    has_been_read = 1'b0;
    m_acl = 16'h0000;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_n"}, start_log.size(), 3);
    for (int i = 0; i < 3; i++) chk({tag, "_ax"}, {30'd0, start_log[i]}, i);
  endtask

  // SPI responder: answers three cycles after each request unless withheld.
  initial begin : spi_model
    logic [1:0] ax;
    spi_done = 1'b0;
    spi_data = '0;
    sb_mark  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (spi_start === 1'b1) begin
        ax = spi_axis;
        start_log.push_back(ax);
        repeat (2) @(posedge clk);
        #1;
        if (!withhold[ax]) begin
          spi_data = samp[ax];
          spi_done = 1'b1;
          if (rst_n) begin
            m_acl = next_word(m_acl, ax, samp[ax], clr_on_z && (ax == 2'd2));
            sb_q.push_back(m_acl);
            sb_mark = 1'b1;
          end
          @(posedge clk); #1;
          spi_done = 1'b0;
          spi_data = '0;
          sb_mark  = 1'b0;
        end
      end
    end
  end

  // Event word must reflect each accepted sample two cycles after spi_done.
  initial begin : sb_check
    logic [1:0]  hist;
    logic [15:0] exp;
    hist = 2'b00;
    forever begin
      @(negedge clk);
      if (hist[1]) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          exp = sb_q.pop_front();
          chk("acl_sb", {16'd0, acl_out}, {16'd0, exp});
        end
      end
      hist = {hist[0], sb_mark};
    end
  end

  initial begin
    int unsigned k;
    rst_n = 1'b0;
    enable = 1'b0;
    has_been_read = 1'b0;
    clr_on_z = 1'b0;
    m_acl = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      samp[i] = 10'd100;
      withhold[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", {31'd0, spi_start}, 32'd0);
    chk("rst_axis", {30'd0, spi_axis}, 32'd0);
    chk("rst_acl", {16'd0, acl_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;

    // 1: below-threshold samples, axis order and busy framing
    start_log.delete();
    wait_busy(1'b1, "t1_busy_hi");
    chk("t1_req_axis", {30'd0, spi_axis}, 32'd0);
    wait_busy(1'b0, "t1_busy_lo");
    check_log("t1_log");
    chk("t1_acl", {16'd0, acl_out}, 32'd0);

    // 2: single negative hit on Y, held across a quiet round
    samp[0] = 10'd0; samp[1] = 10'h270; samp[2] = 10'd0;
    wait_busy(1'b1, "t2_busy_hi");
    wait_busy(1'b0, "t2_busy_lo");
    chk("t2_word", {16'd0, acl_out}, {16'd0, 10'h270, 2'd1, 3'b010, 1'b1});
    samp[1] = 10'd0;
    wait_busy(1'b1, "t2b_busy_hi");
    wait_busy(1'b0, "t2b_busy_lo");
    chk("t2_hold", {16'd0, acl_out}, {16'd0, 10'h270, 2'd1, 3'b010, 1'b1});
    pulse_hbr();
    chk("t2_clr", {16'd0, acl_out}, 32'd0);

    // 3: exact-threshold X first, Z later only ORs into the mask
    samp[0] = 10'd384; samp[1] = 10'd0; samp[2] = 10'd511;
    wait_busy(1'b1, "t3_busy_hi");
    wait_busy(1'b0, "t3_busy_lo");
    chk("t3_mask", {29'd0, acl_out[3:1]}, 32'b101);
    chk("t3_axis", {30'd0, acl_out[5:4]}, 32'd0);
    chk("t3_data", {22'd0, acl_out[15:6]}, 32'd384);
    pulse_hbr();

    // 4: clear coinciding with a Z hit while an X event is pending
    samp[0] = 10'd400; samp[1] = 10'd0; samp[2] = 10'd500;
    clr_on_z = 1'b1;
    wait_start_axis(2'd2, "t4_start_z");
    repeat (3) @(posedge clk);
    #1;
    has_been_read = 1'b1;
    @(posedge clk); #1;
    has_been_read = 1'b0;
    wait_busy(1'b0, "t4_busy_lo");
    clr_on_z = 1'b0;
    chk("t4_word", {16'd0, acl_out}, {16'd0, 10'd500, 2'd2, 3'b100, 1'b1});
    pulse_hbr();

    // 5: Y never answers -> timeout, Z still requested
    samp[0] = 10'd0; samp[1] = 10'd0; samp[2] = 10'd0;
    withhold[1] = 1'b1;
    start_log.delete();
    wait_start_axis(2'd1, "t5_start_y");
    chk("t5_err_pre", {31'd0, err_timeout}, 32'd0);
    k = 0;
    while (err_timeout !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t5_to_lat", k, 32'd9);
    wait_busy(1'b0, "t5_busy_lo");
    withhold[1] = 1'b0;
    check_log("t5_log");
    chk("t5_err_sticky", {31'd0, err_timeout}, 32'd1);
    pulse_hbr();
    chk("t5_err_clr", {31'd0, err_timeout}, 32'd0);

    // 6a: pending event, then reset in the middle of WAIT_DONE
    samp[1] = 10'd450;
    wait_busy(1'b1, "t6_busy_hi");
    wait_busy(1'b0, "t6_busy_lo");
    wait_start_axis(2'd0, "t6_start_x");
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_acl = 16'h0000;
    #1;
    chk("t6_rst_start", {31'd0, spi_start}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_acl", {16'd0, acl_out}, 32'd0);
    chk("t6_rst_axis", {30'd0, spi_axis}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_post_busy", {31'd0, busy}, 32'd0);
    chk("t6_post_acl", {16'd0, acl_out}, 32'd0);

    // 6b: threshold boundaries, enable dropped mid-round
    samp[0] = 10'd383; samp[1] = 10'h281; samp[2] = 10'h200;
    start_log.delete();
    wait_busy(1'b1, "t6b_busy_hi");
    enable = 1'b0;
    wait_busy(1'b0, "t6b_busy_lo");
    check_log("t6b_log");
    chk("t6b_word", {16'd0, acl_out}, {16'd0, 10'h200, 2'd2, 3'b100, 1'b1});
    k = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) k++;
    end
    chk("t6b_idle_busy", k, 32'd0);
    chk("t6b_no_start", start_log.size(), 32'd3);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
